// File: rtl/blk_mem_arbiter.sv
// Round-robin arbiter sharing one block-memory port between an I-side reader
// and a D-side reader/writer, with per-access timeout/retry and a drain mode.
module blk_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLK_W   = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [BLK_W-1:0]  i_data,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [BLK_W-1:0]  d_wdata,
  output logic [BLK_W-1:0]  d_data,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [BLK_W-1:0]  mem_wdata,
  input  logic [BLK_W-1:0]  mem_rdata,
  input  logic              mem_rd_valid,
  input  logic              mem_wr_valid,
  input  logic              sys_drain,
  output logic              drained,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(31);

  typedef enum logic [1:0] {IDLE, ACCESS, RETRY, RESP} state_t;

  state_t            state;
  logic              owner_d;
  logic              op_we;
  logic              last_d;
  logic [ADDR_W-1:0] addr_q;
  logic [BLK_W-1:0]  wdata_q;
  logic [CNT_W-1:0]  cnt;

  logic              i_elig;
  logic              grant_any;
  logic              grant_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic              match;

  // D wins a tie unless D was the last requester granted.
  assign i_elig    = i_req & ~sys_drain;
  assign grant_any = d_req | i_elig;
  assign grant_d   = d_req & (~i_elig | ~last_d);
  assign sel_we    = grant_d & d_we;
  assign sel_addr  = grant_d ? d_addr : i_addr;
  assign match     = op_we ? mem_wr_valid : mem_rd_valid;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  // Gated by reset so every output reads 0 while reset is held.
  assign drained   = RESET & sys_drain & (state == IDLE) & ~d_req;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      op_we       <= 1'b0;
      last_d      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      i_valid     <= 1'b0;
      d_valid     <= 1'b0;
      i_data      <= '0;
      d_data      <= '0;
      timeout_err <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_d <= grant_d;
            last_d  <= grant_d;
            op_we   <= sel_we;
            addr_q  <= sel_addr & ADDR_MASK;
            if (grant_d) wdata_q <= d_wdata;
            cnt     <= '0;
            mem_rd  <= ~sel_we;
            mem_wr  <= sel_we;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (match) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (!op_we) begin
              if (owner_d) d_data <= mem_rdata;
              else         i_data <= mem_rdata;
            end
            if (owner_d) d_valid <= 1'b1;
            else         i_valid <= 1'b1;
            state <= RESP;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            cnt         <= '0;
            state       <= RETRY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RETRY: begin
          mem_rd <= ~op_we;
          mem_wr <= op_we;
          cnt    <= '0;
          state  <= ACCESS;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/blk_mem_arbiter.md
Name: blk_mem_arbiter

Overview:
- Shares the single 256-bit block-memory port between the instruction-side requester (block reads only) and the data-side requester (block reads and block writes).
- Sits between the future I/D caches and the top-level iBlkRead/dBlkRead/dBlkWrite memory interface.
- Round-robin arbitration, one outstanding transaction, per-transaction timeout with retry.
- Drain mode supports SYS: it stops new I-side grants and reports when the port is quiescent.

Parameters:
- ADDR_W, 32, address width.
- BLK_W, 256, block width in bits.
- TIMEOUT, 64, cycles an access may wait for memory valid before retry (>=2).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous reset, active-low.
- i_req  in  1  I-side block read request; held until i_valid.
- i_addr  in  ADDR_W  I-side block address; stable while i_req.
- i_data  out  BLK_W  block returned to I-side.
- i_valid  out  1  one-cycle pulse: i_data valid, I request complete.
- d_req  in  1  D-side request; held until d_valid.
- d_we  in  1  1 = block write, 0 = block read; stable while d_req.
- d_addr  in  ADDR_W  D-side block address.
- d_wdata  in  BLK_W  D-side write block.
- d_data  out  BLK_W  block returned to D-side.
- d_valid  out  1  one-cycle pulse: D request complete (read data valid, or write accepted).
- mem_addr  out  ADDR_W  block address to memory, low 5 bits forced 0.
- mem_rd  out  1  block read request to memory.
- mem_wr  out  1  block write request to memory.
- mem_wdata  out  BLK_W  write block to memory.
- mem_rdata  in  BLK_W  read block from memory.
- mem_rd_valid  in  1  read completed this cycle.
- mem_wr_valid  in  1  write completed this cycle.
- sys_drain  in  1  block new I-side grants.
- drained  out  1  sys_drain high, state IDLE, d_req low.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky: at least one timeout occurred since reset.

Behaviour:
- Reset: while RESET=0, all outputs are 0, state is IDLE, last-grant pointer is I, timeout counter is 0. Asserting reset mid-transaction abandons the transaction immediately; no valid pulse is issued.
- States: IDLE, ACCESS, RETRY, RESP.
- IDLE:
  - Eligible requesters are D if d_req, and I if i_req and !sys_drain.
  - If both are eligible, grant the one not granted last; after reset D wins first.
  - On grant, register requester id, op, address and write data, update the pointer, go to ACCESS.
  - mem_rd/mem_wr assert in the cycle after the grant edge.
- ACCESS:
  - mem_rd = (op == read), mem_wr = (op == write), both held steady.
  - mem_addr and mem_wdata come from the latched registers and do not track input changes.
  - On the matching valid (mem_rd_valid for read, mem_wr_valid for write): capture mem_rdata for reads, go to RESP.
  - A non-matching valid is ignored.
  - The counter increments each ACCESS cycle. If it reaches TIMEOUT-1 without a matching valid, set timeout_err and go to RETRY.
- RETRY: mem_rd = mem_wr = 0 for exactly one cycle, counter cleared, return to ACCESS with the same latched request.
- RESP:
  - The owning requester's valid pulses for exactly this cycle; i_data/d_data hold the captured block (d_data unchanged on writes).
  - Next state is always IDLE.
  - Requests sampled during RESP are ignored, so the requester has one cycle to drop req.
- Latency: a matching memory valid in cycle N gives the requester valid in cycle N+1. Minimum request-to-valid, with memory valid on first mem_rd cycle: 3 cycles.
- i_data/d_data hold their last captured value until the next capture for that side.
- Counter width is clog2(TIMEOUT+1); no wrap, because it is cleared on entering ACCESS and in RETRY.
- sys_drain asserted while an I transaction is in flight: that transaction completes normally; only new I grants are blocked.
- drained is combinational from state, sys_drain and d_req.
- mem_rd and mem_wr are never high together.

Test Plan:
- Single I read, addr 0x0000_1234, memory valid 2 cycles after mem_rd rises: mem_addr = 0x0000_1220; i_valid pulses once with the memory block; d_valid stays 0.
- i_req and d_req (write, addr 0x40) raised in the same cycle after reset: D granted first (mem_wr), then I. Repeat both: order alternates I, D.
- D write with mem_rd_valid pulsed spuriously mid-access: ignored. mem_wr_valid later gives d_valid; d_data unchanged.
- TIMEOUT=8, memory never responds for 8 cycles: timeout_err=1, mem_rd drops for 1 cycle then reasserts. Memory then responds and i_valid pulses; timeout_err stays 1.
- sys_drain=1 with i_req and d_req held: only D is serviced. drained=1 once D completes and d_req drops; I is granted the cycle after sys_drain falls.
- RESET pulled low during ACCESS: mem_rd/mem_wr/busy go 0 asynchronously. After release, no stale valid pulse; the next request is serviced normally.
